// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM mux/demux pair: lane geometry defaults,
// output-register states and the lane bit-offset helper.
package tdm_pkg;

    localparam int unsigned LANES_DEFAULT = 4;
    localparam int unsigned SEL_W_DEFAULT = $clog2(LANES_DEFAULT);

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    function automatic int unsigned lane_lsb(input int unsigned k, input int unsigned data_w);
        return k * data_w;
    endfunction

endpackage

// File: rtl/tdm_demux_out_reg.sv
// One-entry valid/ready holding register: load wins over consume, data keeps
// its last value after it has been taken.
module tdm_out_reg
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    out_state_e state_q;
    out_state_e state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OUT_EMPTY;
            data    <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                data <= load_data;
            end
        end
    end

    // A load in the same cycle as a consume keeps the entry full with no bubble.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            OUT_EMPTY: if (load) state_d = OUT_FULL;
            OUT_FULL: begin
                if (load)       state_d = OUT_FULL;
                else if (ready) state_d = OUT_EMPTY;
            end
            default: state_d = OUT_EMPTY;
        endcase
    end

    assign valid = (state_q == OUT_FULL);

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: steers a serial stream of lane words into lane
// registers and presents each complete frame in parallel with valid/ready.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int unsigned DATA_W = 1,
    parameter int unsigned LANES  = LANES_DEFAULT,
    parameter int unsigned SEL_W  = $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       din,
    input  logic                    din_valid,
    input  logic                    din_sof,
    output logic                    din_ready,
    output logic [LANES*DATA_W-1:0] dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic [SEL_W-1:0]        slot,
    output logic                    frame_err
);

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(LANES - 1);

    // The last lane is never stored: it goes straight into the output register.
    logic [(LANES-1)*DATA_W-1:0] lane_q;
    logic                        accept;
    logic                        complete;

    assign din_ready = ~(dout_valid & ~dout_ready & (slot == LAST_SLOT));
    assign accept    = din_valid & din_ready;
    assign complete  = accept & ~din_sof & (slot == LAST_SLOT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot      <= '0;
            lane_q    <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= accept & din_sof & (slot != '0);
            if (accept) begin
                if (din_sof) begin
                    lane_q[0 +: DATA_W] <= din;
                    slot                <= SEL_W'(1);
                end else begin
                    for (int unsigned k = 0; k < LANES - 1; k++) begin
                        if (slot == SEL_W'(k)) begin
                            lane_q[lane_lsb(k, DATA_W) +: DATA_W] <= din;
                        end
                    end
                    slot <= slot + SEL_W'(1);
                end
            end
        end
    end

    tdm_out_reg #(
        .WIDTH(LANES * DATA_W)
    ) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (complete),
        .load_data({din, lane_q}),
        .ready    (dout_ready),
        .data     (dout),
        .valid    (dout_valid)
    );

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (DATA_W=1, LANES=4) with hand-computed expectations.
module tb_tdm_demux;

    localparam int unsigned DATA_W = 1;
    localparam int unsigned LANES  = 4;
    localparam int unsigned SEL_W  = 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [DATA_W-1:0]       din;
    logic                    din_valid;
    logic                    din_sof;
    logic                    din_ready;
    logic [LANES*DATA_W-1:0] dout;
    logic                    dout_valid;
    logic                    dout_ready;
    logic [SEL_W-1:0]        slot;
    logic                    frame_err;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tdm_demux #(
        .DATA_W(DATA_W),
        .LANES (LANES),
        .SEL_W (SEL_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .din_sof   (din_sof),
        .din_ready (din_ready),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .slot      (slot),
        .frame_err (frame_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic d, input logic sof);
        din       = d;
        din_valid = 1'b1;
        din_sof   = sof;
        tick();
        din_valid = 1'b0;
        din_sof   = 1'b0;
    endtask

    function automatic logic mux4(input logic [3:0] v, input int unsigned s);
        return v[s];
    endfunction

    initial begin
        logic [3:0] pat;

        rst_n      = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        din_sof    = 1'b0;
        dout_ready = 1'b1;

        // 1: reset state, then reset mid-frame
        tick();
        tick();
        chk("rst_dout", dout, 4'h0);
        chk("rst_dout_valid", dout_valid, 1'b0);
        chk("rst_slot", slot, 2'd0);
        chk("rst_frame_err", frame_err, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("rst_din_ready", din_ready, 1'b1);
        send(1'b1, 1'b1);
        send(1'b1, 1'b0);
        chk("partial_slot", slot, 2'd2);
        rst_n = 1'b0;
        #1;
        chk("midrst_slot", slot, 2'd0);
        chk("midrst_dout_valid", dout_valid, 1'b0);
        chk("midrst_dout", dout, 4'h0);
        tick();
        rst_n = 1'b1;
        send(1'b0, 1'b1);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        chk("postrst_dout", dout, 4'b0110);
        chk("postrst_valid", dout_valid, 1'b1);
        chk("postrst_slot", slot, 2'd0);

        // 2: basic frame 1,0,1,1
        send(1'b1, 1'b1);
        chk("basic_valid_mid", dout_valid, 1'b0);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        chk("basic_valid_pre", dout_valid, 1'b0);
        send(1'b1, 1'b0);
        chk("basic_dout", dout, 4'b1101);
        chk("basic_valid", dout_valid, 1'b1);
        tick();
        chk("basic_valid_drop", dout_valid, 1'b0);
        chk("basic_dout_hold", dout, 4'b1101);

        // 3: backpressure, two frames 0xA then 0x5
        dout_ready = 1'b0;
        send(1'b0, 1'b1);
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        chk("bp_f1_dout", dout, 4'b1010);
        chk("bp_f1_valid", dout_valid, 1'b1);
        send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        chk("bp_slot3", slot, 2'd3);
        din       = 1'b0;
        din_valid = 1'b1;
        #1;
        chk("bp_din_ready_low", din_ready, 1'b0);
        tick();
        chk("bp_slot_held", slot, 2'd3);
        chk("bp_f1_held", dout, 4'b1010);
        chk("bp_valid_held", dout_valid, 1'b1);
        dout_ready = 1'b1;
        #1;
        chk("bp_din_ready_high", din_ready, 1'b1);
        tick();
        din_valid = 1'b0;
        chk("bp_f2_dout", dout, 4'b0101);
        chk("bp_f2_valid", dout_valid, 1'b1);
        chk("bp_f2_slot", slot, 2'd0);
        tick();
        chk("bp_drained", dout_valid, 1'b0);

        // 4: resync on SOF at slot 2
        send(1'b1, 1'b1);
        send(1'b1, 1'b0);
        chk("resync_slot2", slot, 2'd2);
        chk("resync_err_idle", frame_err, 1'b0);
        send(1'b0, 1'b1);
        chk("resync_err", frame_err, 1'b1);
        chk("resync_slot1", slot, 2'd1);
        chk("resync_no_partial", dout_valid, 1'b0);
        send(1'b0, 1'b0);
        chk("resync_err_pulse", frame_err, 1'b0);
        send(1'b1, 1'b0);
        chk("resync_still_empty", dout_valid, 1'b0);
        send(1'b1, 1'b0);
        chk("resync_dout", dout, 4'b1100);
        chk("resync_valid", dout_valid, 1'b1);

        // 5: streaming, 8 back-to-back frames
        for (int f = 0; f < 8; f++) begin
            pat = 4'(f * 5 + 3);
            for (int k = 0; k < 4; k++) begin
                din       = pat[k];
                din_valid = 1'b1;
                din_sof   = (k == 0);
                #1;
                chk("stream_din_ready", din_ready, 1'b1);
                tick();
                chk("stream_valid", dout_valid, (k == 3));
                if (k == 3) chk("stream_dout", dout, pat);
            end
        end
        din_valid = 1'b0;
        din_sof   = 1'b0;
        tick();
        chk("stream_end_valid", dout_valid, 1'b0);

        // 6: loopback through a 4:1 mux, every pattern x every select
        for (int p = 0; p < 16; p++) begin
            pat = 4'(p);
            for (int k = 0; k < 4; k++) send(pat[k], (k == 0));
            chk("loop_valid", dout_valid, 1'b1);
            for (int unsigned s = 0; s < 4; s++) begin
                chk("loop_z", mux4(dout, s), pat[s]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
